// File: rtl/abs_encoder_tracker.sv
// Absolute Gray-code encoder front end: synchroniser, run-length debounce, Gray decode,
// multi-turn tracking with jump fault, and windowed signed velocity.
module abs_encoder_tracker #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_STEP      = 4,
  parameter int TURN_BITS     = 8,
  parameter int WINDOW_CYCLES = 100000,
  parameter int VEL_BITS      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     enc_in,
  input  logic                 clear_fault,
  output logic [WIDTH-1:0]     pos,
  output logic [TURN_BITS-1:0] turns,
  output logic                 pos_valid,
  output logic                 step,
  output logic                 dir,
  output logic                 fault,
  output logic [VEL_BITS-1:0]  vel,
  output logic                 vel_strobe
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int WW = $clog2(WINDOW_CYCLES);
  localparam int SW = ((VEL_BITS > WIDTH) ? VEL_BITS : WIDTH) + 1;

  typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;
  state_t state;

  logic [WIDTH-1:0]    sync1, sync2, prev;
  logic [CW-1:0]       run_cnt;
  logic                accept_now, acc_valid;
  logic [WIDTH-1:0]    bin, acc_code;
  logic [WIDTH-1:0]    delta, mag;
  logic                in_range, track_step;
  logic [WW-1:0]       win_cnt;
  logic [VEL_BITS-1:0] vel_acc, vel_sum;
  logic [SW-1:0]       sum_ext;

  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) bin[i] = ^(sync2 >> i);

    // run_cnt holds the number of samples of the current code seen so far, so a
    // run of exactly STABLE_CYCLES samples is enough; acceptance is registered once.
    accept_now = (sync2 != prev) ? (STABLE_CYCLES == 1)
                                 : (run_cnt == CW'(STABLE_CYCLES - 1));

    delta      = acc_code - pos;
    mag        = delta[WIDTH-1] ? (~delta + 1'b1) : delta;
    in_range   = (delta != '0) && (mag <= WIDTH'(MAX_STEP));
    track_step = (state == TRACK) && acc_valid && in_range;

    sum_ext = {{(SW-VEL_BITS){vel_acc[VEL_BITS-1]}}, vel_acc}
            + (track_step ? {{(SW-WIDTH){delta[WIDTH-1]}}, delta} : '0);
    vel_sum = sum_ext[VEL_BITS-1:0];
    if (!(sum_ext[SW-1:VEL_BITS-1] == '0 || sum_ext[SW-1:VEL_BITS-1] == '1))
      vel_sum = {sum_ext[SW-1], {(VEL_BITS-1){~sum_ext[SW-1]}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      run_cnt    <= '0;
      acc_valid  <= 1'b0;
      acc_code   <= '0;
      state      <= INIT;
      pos        <= '0;
      turns      <= '0;
      pos_valid  <= 1'b0;
      step       <= 1'b0;
      dir        <= 1'b0;
      fault      <= 1'b0;
      win_cnt    <= '0;
      vel_acc    <= '0;
      vel        <= '0;
      vel_strobe <= 1'b0;
    end else begin
      sync1 <= enc_in;
      sync2 <= sync1;
      prev  <= sync2;
      if (sync2 != prev)
        run_cnt <= CW'(1);
      else if (run_cnt != CW'(STABLE_CYCLES))
        run_cnt <= run_cnt + 1'b1;
      acc_valid <= accept_now;
      if (accept_now) acc_code <= bin;

      step <= 1'b0;
      case (state)
        INIT: begin
          if (acc_valid) begin
            pos       <= acc_code;
            pos_valid <= 1'b1;
            state     <= TRACK;
          end
        end
        TRACK: begin
          if (acc_valid && delta != '0) begin
            if (in_range) begin
              pos  <= acc_code;
              step <= 1'b1;
              dir  <= ~delta[WIDTH-1];
              if (!delta[WIDTH-1] && acc_code < pos)
                turns <= turns + 1'b1;
              else if (delta[WIDTH-1] && acc_code > pos)
                turns <= turns - 1'b1;
            end else begin
              fault     <= 1'b1;
              pos_valid <= 1'b0;
              state     <= FAULT;
            end
          end
        end
        FAULT: begin
          if (clear_fault) begin
            fault <= 1'b0;
            state <= INIT;
          end
        end
        default: state <= INIT;
      endcase

      if (win_cnt == WW'(WINDOW_CYCLES - 1)) begin
        win_cnt    <= '0;
        vel        <= vel_sum;
        vel_strobe <= 1'b1;
        vel_acc    <= '0;
      end else begin
        win_cnt    <= win_cnt + 1'b1;
        vel_strobe <= 1'b0;
        vel_acc    <= vel_sum;
      end
    end
  end
endmodule

// File: tb/tb_abs_encoder_tracker.sv
// Directed bench for abs_encoder_tracker (WIDTH=8, STABLE_CYCLES=4, MAX_STEP=4, WINDOW_CYCLES=50).
module tb_abs_encoder_tracker;
  logic        clk = 1'b0;
  logic        rst, clear_fault;
  logic [7:0]  enc_in, pos, turns;
  logic        pos_valid, step, dir, fault, vel_strobe;
  logic [15:0] vel;
  int checks = 0;
  int failures = 0;

  abs_encoder_tracker #(
    .WIDTH(8), .STABLE_CYCLES(4), .MAX_STEP(4),
    .TURN_BITS(8), .WINDOW_CYCLES(50), .VEL_BITS(16)
  ) dut (
    .clk(clk), .rst(rst), .enc_in(enc_in), .clear_fault(clear_fault),
    .pos(pos), .turns(turns), .pos_valid(pos_valid), .step(step), .dir(dir),
    .fault(fault), .vel(vel), .vel_strobe(vel_strobe)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] b);
    enc_in = gray(b); clear_fault = 1'b0; rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    enc_in = gray(8'd10); clear_fault = 1'b0; rst = 1'b1;
    tick(3);
    checks++; if ({pos, turns, pos_valid, step, dir, fault, vel, vel_strobe} !== 36'h0) begin
      failures++; $display("FAIL reset_values got=%h exp=0", {pos, turns, pos_valid, step, dir, fault, vel, vel_strobe}); end
    rst = 1'b0;
    tick(6);
    checks++; if (pos_valid !== 1'b0) begin failures++; $display("FAIL early_valid got=%b exp=0", pos_valid); end
    tick(1);
    checks++; if ({pos, pos_valid, step, turns} !== {8'd10, 1'b1, 1'b0, 8'd0}) begin
      failures++; $display("FAIL init_load got pos=%0d v=%b step=%b turns=%0d exp 10 1 0 0", pos, pos_valid, step, turns); end
  endtask

  task automatic test_wrap;
    start(8'd254); tick(7);
    checks++; if (pos !== 8'd254) begin failures++; $display("FAIL wrap_init got=%0d exp=254", pos); end
    enc_in = gray(8'd255); tick(7);
    checks++; if ({pos, step, dir, turns} !== {8'd255, 1'b1, 1'b1, 8'd0}) begin
      failures++; $display("FAIL fwd_255 got pos=%0d step=%b dir=%b turns=%0d exp 255 1 1 0", pos, step, dir, turns); end
    tick(1);
    checks++; if (step !== 1'b0) begin failures++; $display("FAIL step_pulse got=%b exp=0", step); end
    enc_in = gray(8'd0); tick(7);
    checks++; if ({pos, step, dir, turns} !== {8'd0, 1'b1, 1'b1, 8'd1}) begin
      failures++; $display("FAIL fwd_wrap got pos=%0d step=%b dir=%b turns=%0d exp 0 1 1 1", pos, step, dir, turns); end
    enc_in = gray(8'd255); tick(7);
    checks++; if ({pos, step, dir, turns} !== {8'd255, 1'b1, 1'b0, 8'd0}) begin
      failures++; $display("FAIL rev_wrap got pos=%0d step=%b dir=%b turns=%0d exp 255 1 0 0", pos, step, dir, turns); end
    enc_in = gray(8'd254); tick(7);
    checks++; if ({pos, step, dir, turns} !== {8'd254, 1'b1, 1'b0, 8'd0}) begin
      failures++; $display("FAIL rev_254 got pos=%0d step=%b dir=%b turns=%0d exp 254 1 0 0", pos, step, dir, turns); end
  endtask

  task automatic test_glitch;
    logic seen;
    enc_in = gray(8'd254) ^ 8'h01; tick(3);
    enc_in = gray(8'd254);
    seen = 1'b0;
    repeat (10) begin tick(1); if (step) seen = 1'b1; end
    checks++; if ({seen, pos} !== {1'b0, 8'd254}) begin
      failures++; $display("FAIL glitch3 got step_seen=%b pos=%0d exp 0 254", seen, pos); end
    enc_in = gray(8'd254) ^ 8'h01; tick(4);
    enc_in = gray(8'd254); tick(3);
    checks++; if ({pos, step, dir} !== {8'd255, 1'b1, 1'b1}) begin
      failures++; $display("FAIL hold4 got pos=%0d step=%b dir=%b exp 255 1 1", pos, step, dir); end
    tick(4);
    checks++; if ({pos, step, dir} !== {8'd254, 1'b1, 1'b0}) begin
      failures++; $display("FAIL hold4_back got pos=%0d step=%b dir=%b exp 254 1 0", pos, step, dir); end
  endtask

  task automatic test_fault;
    start(8'd2); tick(7);
    enc_in = gray(8'd254); tick(7);
    checks++; if ({pos, step, dir, turns} !== {8'd254, 1'b1, 1'b0, 8'hFF}) begin
      failures++; $display("FAIL max_step_wrap got pos=%0d step=%b dir=%b turns=%h exp 254 1 0 ff", pos, step, dir, turns); end
    enc_in = gray(8'd3); tick(6);
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL fault_early got=%b exp=0", fault); end
    tick(1);
    checks++; if ({fault, pos_valid, pos, turns, step} !== {1'b1, 1'b0, 8'd254, 8'hFF, 1'b0}) begin
      failures++; $display("FAIL jump5 got f=%b v=%b pos=%0d turns=%h step=%b exp 1 0 254 ff 0", fault, pos_valid, pos, turns, step); end
    enc_in = gray(8'd4); tick(7);
    checks++; if ({fault, pos} !== {1'b1, 8'd254}) begin
      failures++; $display("FAIL fault_ignores got f=%b pos=%0d exp 1 254", fault, pos); end
    clear_fault = 1'b1; tick(1); clear_fault = 1'b0;
    checks++; if ({fault, pos_valid} !== 2'b00) begin
      failures++; $display("FAIL clear got f=%b v=%b exp 0 0", fault, pos_valid); end
    enc_in = gray(8'd20); tick(7);
    checks++; if ({pos, pos_valid, turns, step} !== {8'd20, 1'b1, 8'hFF, 1'b0}) begin
      failures++; $display("FAIL reload got pos=%0d v=%b turns=%h step=%b exp 20 1 ff 0", pos, pos_valid, turns, step); end
    enc_in = gray(8'd30); tick(7);
    checks++; if ({fault, pos_valid, pos} !== {1'b1, 1'b0, 8'd20}) begin
      failures++; $display("FAIL jump10 got f=%b v=%b pos=%0d exp 1 0 20", fault, pos_valid, pos); end
    enc_in = gray(8'd25); tick(6);
    clear_fault = 1'b1; tick(1); clear_fault = 1'b0;
    tick(7);
    checks++; if ({fault, pos_valid, pos} !== {1'b0, 1'b0, 8'd20}) begin
      failures++; $display("FAIL clear_wins got f=%b v=%b pos=%0d exp 0 0 20", fault, pos_valid, pos); end
    enc_in = gray(8'd2); tick(7);
    checks++; if ({pos, pos_valid, turns} !== {8'd2, 1'b1, 8'hFF}) begin
      failures++; $display("FAIL reload2 got pos=%0d v=%b turns=%h exp 2 1 ff", pos, pos_valid, turns); end
  endtask

  task automatic test_reset_mid;
    clear_fault = 1'b1; tick(1); clear_fault = 1'b0;
    checks++; if ({fault, pos_valid, pos} !== {1'b0, 1'b1, 8'd2}) begin
      failures++; $display("FAIL clear_in_track got f=%b v=%b pos=%0d exp 0 1 2", fault, pos_valid, pos); end
    enc_in = gray(8'd254); tick(7);
    checks++; if ({pos, turns} !== {8'd254, 8'hFE}) begin
      failures++; $display("FAIL turns_m2 got pos=%0d turns=%h exp 254 fe", pos, turns); end
    rst = 1'b1; tick(1);
    checks++; if ({pos, turns, pos_valid, step, dir, fault, vel, vel_strobe} !== 36'h0) begin
      failures++; $display("FAIL mid_reset got=%h exp=0", {pos, turns, pos_valid, step, dir, fault, vel, vel_strobe}); end
    rst = 1'b0;
  endtask

  task automatic test_velocity;
    logic all_step;
    start(8'd100); tick(7);
    all_step = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      enc_in = gray(8'(100 + i)); tick(7);
      if (step !== 1'b1) all_step = 1'b0;
    end
    checks++; if ({all_step, pos} !== {1'b1, 8'd105}) begin
      failures++; $display("FAIL vel_steps got all=%b pos=%0d exp 1 105", all_step, pos); end
    tick(7);
    checks++; if (vel_strobe !== 1'b0) begin failures++; $display("FAIL strobe_early got=%b exp=0", vel_strobe); end
    tick(1);
    checks++; if ({vel_strobe, vel} !== {1'b1, 16'd5}) begin
      failures++; $display("FAIL vel_win1 got strobe=%b vel=%0d exp 1 5", vel_strobe, vel); end
    tick(1);
    checks++; if ({vel_strobe, vel} !== {1'b0, 16'd5}) begin
      failures++; $display("FAIL strobe_len got strobe=%b vel=%0d exp 0 5", vel_strobe, vel); end
    tick(49);
    checks++; if ({vel_strobe, vel} !== {1'b1, 16'd0}) begin
      failures++; $display("FAIL vel_win2 got strobe=%b vel=%0d exp 1 0", vel_strobe, vel); end
  endtask

  initial begin
    rst = 1'b1; clear_fault = 1'b0; enc_in = '0;
    test_reset;
    test_wrap;
    test_glitch;
    test_fault;
    test_reset_mid;
    test_velocity;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
